// File: rtl/cdma_rd_responder_if.sv
// Request, response, memory-read and status signals of the CDMA read responder.
// The responder takes the slave modport; the requester/memory side takes master.
interface cdma_rd_responder_if #(
  parameter int unsigned ADDR_W = 12
);
  logic              io_rd_req_valid;
  logic              io_rd_req_ready;
  logic [78:0]       io_rd_req_bits;
  logic              io_rd_rsp_valid;
  logic              io_rd_rsp_ready;
  logic [256:0]      io_rd_rsp_bits;
  logic              io_mem_rd_en;
  logic [ADDR_W-1:0] io_mem_rd_addr;
  logic [255:0]      io_mem_rd_data;
  logic              io_busy;
  logic              io_misalign_err;
  logic [31:0]       io_beat_cnt;

  modport slave (
    input  io_rd_req_valid, io_rd_req_bits, io_rd_rsp_ready, io_mem_rd_data,
    output io_rd_req_ready, io_rd_rsp_valid, io_rd_rsp_bits, io_mem_rd_en,
           io_mem_rd_addr, io_busy, io_misalign_err, io_beat_cnt
  );

  modport master (
    output io_rd_req_valid, io_rd_req_bits, io_rd_rsp_ready, io_mem_rd_data,
    input  io_rd_req_ready, io_rd_rsp_valid, io_rd_rsp_bits, io_mem_rd_en,
           io_mem_rd_addr, io_busy, io_misalign_err, io_beat_cnt
  );
endinterface

// File: rtl/cdma_rd_responder.sv
// Turns queued (address, atom count) read requests into one-atom-per-cycle memory
// reads and returns the data in order through a 2-entry skid buffer.
module cdma_rd_responder #(
  parameter int unsigned ADDR_W    = 12,
  parameter int unsigned REQ_DEPTH = 4
) (
  input logic                clock,
  input logic                reset,
  cdma_rd_responder_if.slave io
);
  localparam int unsigned PTR_W  = $clog2(REQ_DEPTH);
  localparam int unsigned SIZE_W = 15;
  localparam int unsigned DATA_W = 256;

  typedef enum logic {IDLE, BURST} state_t;

  state_t state, state_nxt;

  logic [ADDR_W-1:0] fifo_idx  [REQ_DEPTH];
  logic [SIZE_W-1:0] fifo_size [REQ_DEPTH];
  logic [PTR_W:0]    wr_ptr, rd_ptr;
  logic              fifo_full, fifo_empty, fifo_push, fifo_pop;

  logic [ADDR_W-1:0] idx;
  logic [SIZE_W-1:0] rem;
  logic              rd_en, inflight, issue_ok;

  logic [DATA_W-1:0] buf_data [2];
  logic              buf_wr, buf_rd;
  logic [1:0]        occ;
  logic              rsp_pop;
  logic [2:0]        occ_proj;
  logic              unused_req_bits;

  assign unused_req_bits = ^io.io_rd_req_bits[63:ADDR_W+5];

  // Request FIFO, first-word fall-through from the storage array
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                      (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign fifo_push  = io.io_rd_req_valid && io.io_rd_req_ready;

  always_ff @(posedge clock) begin
    if (fifo_push) begin
      fifo_idx[wr_ptr[PTR_W-1:0]]  <= io.io_rd_req_bits[ADDR_W+4:5];
      fifo_size[wr_ptr[PTR_W-1:0]] <= io.io_rd_req_bits[78:64];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (fifo_push) wr_ptr <= wr_ptr + (PTR_W+1)'(1);
      if (fifo_pop)  rd_ptr <= rd_ptr + (PTR_W+1)'(1);
    end
  end

  // Issue only if the beat will have a buffer slot when it returns
  assign rsp_pop  = !reset && (occ != 2'd0) && io.io_rd_rsp_ready;
  assign occ_proj = 3'(occ) + 3'(inflight) - 3'(rsp_pop);
  assign issue_ok = (occ_proj < 3'd2);

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (!fifo_empty) state_nxt = BURST;
      BURST:   if (issue_ok && (rem == '0)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    fifo_pop = 1'b0;
    rd_en    = 1'b0;
    if (!reset) begin
      unique case (state)
        IDLE:    fifo_pop = !fifo_empty;
        BURST:   rd_en    = issue_ok;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      idx <= '0;
      rem <= '0;
    end else if (fifo_pop) begin
      idx <= fifo_idx[rd_ptr[PTR_W-1:0]];
      rem <= fifo_size[rd_ptr[PTR_W-1:0]];
    end else if (rd_en) begin
      idx <= idx + ADDR_W'(1);
      rem <= rem - SIZE_W'(1);
    end
  end

  // Return buffer: memory data lands one cycle after the read strobe
  always_ff @(posedge clock) begin
    if (inflight) buf_data[buf_wr] <= io.io_mem_rd_data;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      inflight <= 1'b0;
      buf_wr   <= 1'b0;
      buf_rd   <= 1'b0;
      occ      <= 2'd0;
    end else begin
      inflight <= rd_en;
      if (inflight) buf_wr <= ~buf_wr;
      if (rsp_pop)  buf_rd <= ~buf_rd;
      occ <= occ + 2'(inflight) - 2'(rsp_pop);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      io.io_misalign_err <= 1'b0;
      io.io_beat_cnt     <= '0;
    end else begin
      if (fifo_push && (io.io_rd_req_bits[4:0] != 5'd0)) io.io_misalign_err <= 1'b1;
      if (rsp_pop) io.io_beat_cnt <= io.io_beat_cnt + 32'd1;
    end
  end

  assign io.io_rd_req_ready = !reset && !fifo_full;
  assign io.io_rd_rsp_valid = !reset && (occ != 2'd0);
  assign io.io_rd_rsp_bits  = {1'b1, buf_data[buf_rd]};
  assign io.io_mem_rd_en    = rd_en;
  assign io.io_mem_rd_addr  = idx;
  assign io.io_busy         = !reset && (!fifo_empty || (state == BURST) ||
                                         inflight || (occ != 2'd0));
endmodule

// File: tb/tb_cdma_rd_responder.sv
// Directed bench for cdma_rd_responder: memory model, in-order scoreboard of
// read indices and response beats, and hand-computed status checks.
module tb_cdma_rd_responder;
  localparam int unsigned ADDR_W = 12;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  cdma_rd_responder_if #(.ADDR_W(ADDR_W)) io ();

  cdma_rd_responder #(.ADDR_W(ADDR_W), .REQ_DEPTH(4)) dut (
    .clock(clock),
    .reset(reset),
    .io   (io)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [256:0] obs, input logic [256:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] mem_word(input int unsigned a);
    logic [255:0] d;
    for (int w = 0; w < 8; w++)
      d[w*32 +: 32] = (a * 32'h0100_0193) ^ (32'(w) << 24) ^ 32'hC0DE_0000;
    return d;
  endfunction

  // Memory: data for the strobed index one cycle later, garbage otherwise
  always @(posedge clock) begin
    if (io.io_mem_rd_en) io.io_mem_rd_data <= mem_word(32'(io.io_mem_rd_addr));
    else                 io.io_mem_rd_data <= {8{$urandom}};
  end

  int unsigned exp_addr[$];
  int unsigned exp_rsp[$];
  int          outstanding;
  logic        prev_stall;
  logic [256:0] prev_bits;

  always @(posedge clock) begin
    if (reset) outstanding <= 0;
    else outstanding <= outstanding + (io.io_mem_rd_en ? 1 : 0)
                        - ((io.io_rd_rsp_valid && io.io_rd_rsp_ready) ? 1 : 0);
  end

  // Scoreboard: read strobes and popped beats must follow request/address order
  always @(negedge clock) begin
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      if (io.io_mem_rd_en) begin
        if (exp_addr.size() == 0) check_eq("rd_extra", 257'(io.io_mem_rd_en), 257'd0);
        else check_eq("rd_addr", 257'(io.io_mem_rd_addr), 257'(exp_addr.pop_front()));
      end
      if (io.io_rd_rsp_valid) begin
        check_eq("inflight_bound", 257'(outstanding > 2), 257'd0);
        if (prev_stall) check_eq("rsp_hold", io.io_rd_rsp_bits, prev_bits);
        if (io.io_rd_rsp_ready) begin
          if (exp_rsp.size() == 0) check_eq("rsp_extra", 257'(io.io_rd_rsp_valid), 257'd0);
          else check_eq("rsp_bits", io.io_rd_rsp_bits, {1'b1, mem_word(exp_rsp.pop_front())});
        end
      end
      prev_stall = io.io_rd_rsp_valid && !io.io_rd_rsp_ready;
      prev_bits  = io.io_rd_rsp_bits;
    end
  end

  logic       bp_en = 1'b0;
  logic [3:0] bp_pat = 4'b1001;
  int         bp_ph = 0;

  always @(posedge clock) begin
    if (bp_en) begin
      #1;
      io.io_rd_rsp_ready = bp_pat[bp_ph % 4];
      bp_ph++;
    end
  end

  task automatic add_exp(input logic [63:0] addr, input logic [14:0] size);
    int unsigned base;
    base = 32'(addr[ADDR_W+4:5]);
    for (int i = 0; i <= int'(size); i++) begin
      exp_addr.push_back((base + 32'(i)) % 4096);
      exp_rsp.push_back((base + 32'(i)) % 4096);
    end
  endtask

  task automatic handshake(input logic [63:0] addr, input logic [14:0] size);
    int n;
    n = 0;
    io.io_rd_req_bits  = {size, addr};
    io.io_rd_req_valid = 1'b1;
    @(negedge clock);
    while (!io.io_rd_req_ready && n < 500) begin
      n++;
      @(negedge clock);
    end
    if (!io.io_rd_req_ready) check_eq("push_timeout", 257'(io.io_rd_req_ready), 257'd1);
    @(posedge clock);
    #1;
    io.io_rd_req_valid = 1'b0;
  endtask

  task automatic push(input logic [63:0] addr, input logic [14:0] size);
    add_exp(addr, size);
    handshake(addr, size);
  endtask

  task automatic wait_done(input int bound);
    int n;
    n = 0;
    @(negedge clock);
    while ((io.io_busy || exp_rsp.size() != 0) && n < bound) begin
      n++;
      @(negedge clock);
    end
    check_eq("drain_busy", 257'(io.io_busy), 257'd0);
    check_eq("drain_left", 257'(exp_rsp.size()), 257'd0);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    int n;
    io.io_rd_req_valid = 1'b0;
    io.io_rd_req_bits  = '0;
    io.io_rd_rsp_ready = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check_eq("rst_req_ready", 257'(io.io_rd_req_ready), 257'd0);
    check_eq("rst_rsp_valid", 257'(io.io_rd_rsp_valid), 257'd0);
    check_eq("rst_rd_en",     257'(io.io_mem_rd_en),    257'd0);
    check_eq("rst_busy",      257'(io.io_busy),         257'd0);
    tick();
    reset = 1'b0;
    @(negedge clock);
    check_eq("post_rst_ready", 257'(io.io_rd_req_ready), 257'd1);
    check_eq("post_rst_busy",  257'(io.io_busy),         257'd0);
    check_eq("post_rst_cnt",   257'(io.io_beat_cnt),     257'd0);
    check_eq("post_rst_err",   257'(io.io_misalign_err), 257'd0);
    tick();

    // Single beat at atom 2
    io.io_rd_rsp_ready = 1'b1;
    push(64'h40, 15'd0);
    wait_done(50);
    check_eq("single_cnt", 257'(io.io_beat_cnt), 257'd1);
    tick();

    // Back-to-back bursts: atoms 0-3 then 128-129
    push(64'h0, 15'd3);
    push(64'h1000, 15'd1);
    wait_done(100);
    check_eq("b2b_cnt", 257'(io.io_beat_cnt), 257'd7);
    tick();

    // Backpressure 1,0,0,1 over an 8-beat burst
    bp_en = 1'b1;
    push(64'h200, 15'd7);
    wait_done(200);
    bp_en = 1'b0;
    check_eq("bp_cnt", 257'(io.io_beat_cnt), 257'd15);
    tick();
    io.io_rd_rsp_ready = 1'b1;

    // Fill the request FIFO while responses are blocked
    io.io_rd_rsp_ready = 1'b0;
    for (int k = 0; k < 5; k++) push(64'h400 + 64'(k) * 64'h80, 15'd3);
    @(negedge clock);
    check_eq("full_ready", 257'(io.io_rd_req_ready), 257'd0);
    tick();
    add_exp(64'h680, 15'd3);
    io.io_rd_req_bits  = {15'd3, 64'h680};
    io.io_rd_req_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      check_eq("sixth_stalled", 257'(io.io_rd_req_ready), 257'd0);
    end
    tick();
    io.io_rd_rsp_ready = 1'b1;
    handshake(64'h680, 15'd3);
    wait_done(300);
    check_eq("full_cnt", 257'(io.io_beat_cnt), 257'd39);
    tick();

    // Index wrap 4095 -> 0 -> 1 with a misaligned address
    check_eq("err_before", 257'(io.io_misalign_err), 257'd0);
    push(64'h1FFE3, 15'd2);
    wait_done(100);
    check_eq("err_set", 257'(io.io_misalign_err), 257'd1);
    check_eq("wrap_cnt", 257'(io.io_beat_cnt), 257'd42);
    tick();
    push(64'h20, 15'd0);
    wait_done(50);
    check_eq("err_sticky", 257'(io.io_misalign_err), 257'd1);
    check_eq("aligned_cnt", 257'(io.io_beat_cnt), 257'd43);
    tick();

    // Reset five beats into a 16-beat burst
    push(64'h0, 15'd15);
    n = 0;
    @(negedge clock);
    while (io.io_beat_cnt != 32'd48 && n < 200) begin
      n++;
      @(negedge clock);
    end
    check_eq("mid_cnt", 257'(io.io_beat_cnt), 257'd48);
    tick();
    reset = 1'b1;
    exp_addr.delete();
    exp_rsp.delete();
    @(negedge clock);
    check_eq("mid_rst_ready", 257'(io.io_rd_req_ready), 257'd0);
    check_eq("mid_rst_valid", 257'(io.io_rd_rsp_valid), 257'd0);
    check_eq("mid_rst_rd_en", 257'(io.io_mem_rd_en),    257'd0);
    check_eq("mid_rst_busy",  257'(io.io_busy),         257'd0);
    tick();
    reset = 1'b0;
    @(negedge clock);
    check_eq("after_ready", 257'(io.io_rd_req_ready), 257'd1);
    check_eq("after_cnt",   257'(io.io_beat_cnt),     257'd0);
    check_eq("after_err",   257'(io.io_misalign_err), 257'd0);
    check_eq("after_busy",  257'(io.io_busy),         257'd0);
    for (int k = 0; k < 5; k++) begin
      check_eq("no_stale_valid", 257'(io.io_rd_rsp_valid), 257'd0);
      check_eq("no_stale_rd_en", 257'(io.io_mem_rd_en),    257'd0);
      @(negedge clock);
    end
    check_eq("final_cnt", 257'(io.io_beat_cnt), 257'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end
endmodule

// File: doc/cdma_rd_responder.md
CDMA_RD_RESPONDER -- requirements
Module: cdma_rd_responder

Interface
REQ-001 Parameter ADDR_W, default 12: width of the memory atom index; one atom is 32 bytes.
REQ-002 Parameter REQ_DEPTH, default 4: number of request FIFO entries; a power of two, at least 2.
REQ-003 Port clock, input, 1: sole clock; all state updates on the rising edge.
REQ-004 Port reset, input, 1: synchronous, active-high reset.
REQ-005 Port io_rd_req_valid, input, 1: request valid.
REQ-006 Port io_rd_req_ready, output, 1: request accept.
REQ-007 Port io_rd_req_bits, input, 79: [63:0] byte address; [78:64] size, as atom count minus 1.
REQ-008 Port io_rd_rsp_valid, output, 1: response beat valid.
REQ-009 Port io_rd_rsp_ready, input, 1: downstream accept.
REQ-010 Port io_rd_rsp_bits, output, 257: [255:0] atom data; [256] mask, always 1.
REQ-011 Port io_mem_rd_en, output, 1: memory read strobe.
REQ-012 Port io_mem_rd_addr, output, ADDR_W: atom index.
REQ-013 Port io_mem_rd_data, input, 256: read data, valid exactly 1 cycle after io_mem_rd_en.
REQ-014 Port io_busy, output, 1: high when any request is queued, in burst, or beat in flight/buffered.
REQ-015 Port io_misalign_err, output, 1: sticky flag; set on an accepted request with addr[4:0] != 0.
REQ-016 Port io_beat_cnt, output, 32: count of completed response beats; wraps modulo 2^32.

Function
REQ-017 Request FIFO: io_rd_req_ready = not full; push on valid&&ready; when full, ready stays low even if the same cycle pops.
REQ-018 Request FIFO is first-word fall-through; a request pushed in cycle N is poppable by the FSM in cycle N+1, not N.
REQ-019 FSM has two states, IDLE and BURST.
REQ-020 IDLE to BURST: when the FIFO is non-empty, pop its head in that cycle; load idx = addr[ADDR_W+4:5] and rem = size (15 bits).
REQ-021 BURST issue: when issue_ok, assert io_mem_rd_en with io_mem_rd_addr = idx; then idx increments modulo 2^ADDR_W (silent wrap) and rem decrements.
REQ-022 BURST to IDLE: when issuing with rem == 0; no idle cycle is needed between back-to-back requests beyond the IDLE pop cycle.
REQ-023 Address bits [63:ADDR_W+5] and [4:0] are ignored for addressing; misalignment sets io_misalign_err but does not alter data.
REQ-024 Output buffer is a 2-entry FIFO of returned data; inflight is a 1-bit register = io_mem_rd_en of the previous cycle.
REQ-025 issue_ok = (occ + inflight - pop) < 2, where occ is buffer occupancy and pop = io_rd_rsp_valid && io_rd_rsp_ready; this sustains 1 beat/cycle with ready held high.
REQ-026 Returning io_mem_rd_data is written into the buffer in the cycle after issue; the buffer never overflows and data is never dropped.
REQ-027 io_rd_rsp_valid = occ != 0; head bits stay stable while valid && !ready.
REQ-028 Beats are returned strictly in request order and address order.
REQ-029 io_beat_cnt increments by 1 on each pop.
REQ-030 Size 32767 (32768 atoms) is legal; rem counts down without overflow.

Reset
REQ-031 On reset, empty both FIFOs, set FSM to IDLE, and clear inflight, idx, rem, io_misalign_err and io_beat_cnt.
REQ-032 Outputs during and after reset: io_rd_req_ready = 0 while reset is high and 1 in the first cycle after; io_rd_rsp_valid = 0; io_mem_rd_en = 0; io_busy = 0.
REQ-033 Reset asserted mid-burst aborts the burst; a memory beat returning in the cycle after reset is discarded.

Verification
REQ-034 Single-beat request: addr 0x40, size 0, rsp_ready = 1. Expect mem_rd_en with addr 2, one beat with mem[2] data and bit256 = 1, beat_cnt = 1, busy then 0.
REQ-035 Back-to-back requests: (addr 0x0, size 3) then (addr 0x1000, size 1), rsp_ready = 1. Expect 6 beats in order, indices 0-3 then 128-129, with consecutive beats inside each burst.
REQ-036 Backpressure: size 7 with rsp_ready toggled 1,0,0,1 repeating. Expect all 8 beats in order, stable bits while stalled, and never more than 2 buffered plus in-flight beats.
REQ-037 FIFO full: 5 requests pushed while rsp_ready = 0. Expect req_ready low after 4 queued plus 1 popped by the FSM; the 6th push is stalled.
REQ-038 Wrap and misalignment: addr 0x1FFE3, size 2, ADDR_W = 12. Expect indices 4095, 0, 1 and misalign_err = 1, held until reset.
REQ-039 Mid-burst reset: reset during size 15 after 5 beats. Expect all outputs at reset values the next cycle, no stale beat afterwards, and beat_cnt = 0.
